// File: rtl/io_port_periph_pkg.sv
// Shared CPU-side definitions for the I/O port peripheral: port width,
// FIFO depth defaults, pointer sizing and the sticky error flag bundle.
package io_port_periph_pkg;

  localparam int CPU_DW     = 8;
  localparam int FIFO_DEPTH = 4;

  // Sticky error flags kept by the peripheral.
  typedef struct packed {
    logic in_underflow;
    logic out_overflow;
  } err_flags_t;

  // Read/write pointer width for a power-of-two FIFO depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/io_port_periph_if.sv
// Bus bundle between the host side, the CPU port side and the I/O peripheral.
// The slave modport is the peripheral's view, master is the environment's.
interface io_port_periph_if import io_port_periph_pkg::*; #(
  parameter int DW = CPU_DW
);

  logic [DW-1:0] host_in_data;
  logic          host_in_valid;
  logic          host_in_ready;
  logic [DW-1:0] cpu_i_port;
  logic          cpu_in_rd;
  logic [DW-1:0] cpu_o_port;
  logic          cpu_out_wr;
  logic [DW-1:0] host_out_data;
  logic          host_out_valid;
  logic          host_out_ready;
  logic          int_en;
  logic          cpu_int_sig;
  logic          clr_flags;
  logic          in_underflow;
  logic          out_overflow;

  modport slave (
    input  host_in_data, host_in_valid, cpu_in_rd, cpu_o_port, cpu_out_wr,
           host_out_ready, int_en, clr_flags,
    output host_in_ready, cpu_i_port, host_out_data, host_out_valid,
           cpu_int_sig, in_underflow, out_overflow
  );

  modport master (
    output host_in_data, host_in_valid, cpu_in_rd, cpu_o_port, cpu_out_wr,
           host_out_ready, int_en, clr_flags,
    input  host_in_ready, cpu_i_port, host_out_data, host_out_valid,
           cpu_int_sig, in_underflow, out_overflow
  );

endinterface

// File: rtl/io_port_periph_sync_fifo.sv
// Synchronous FIFO with a combinational head. Pops on empty are ignored;
// a push while full is accepted only when a pop frees the slot in the
// same edge. The head reads as zero while the FIFO is empty.
module sync_fifo import io_port_periph_pkg::*; #(
  parameter int DW    = CPU_DW,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, written on accepted pushes only; never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_port_periph.sv
// I/O port peripheral: an input FIFO feeding CPU IN instructions, an output
// FIFO capturing CPU OUT instructions, an edge-triggered interrupt on the
// input FIFO becoming non-empty, and sticky underflow/overflow flags.
module io_port_periph import io_port_periph_pkg::*; #(
  parameter int DW    = CPU_DW,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  io_port_periph_if.slave  bus
);

  logic       in_full, in_empty, in_push;
  logic       out_full, out_empty;
  logic       int_q, int_d;
  err_flags_t flags_q, flags_d;

  assign in_push = bus.host_in_valid && !in_full;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_in_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (in_push),
    .pop_i   (bus.cpu_in_rd),
    .wdata_i (bus.host_in_data),
    .full_o  (in_full),
    .empty_o (in_empty),
    .head_o  (bus.cpu_i_port)
  );

  // A write into a full output FIFO lands only if the host pops the same
  // edge; the FIFO itself resolves that case.
  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (bus.cpu_out_wr),
    .pop_i   (bus.host_out_ready),
    .wdata_i (bus.cpu_o_port),
    .full_o  (out_full),
    .empty_o (out_empty),
    .head_o  (bus.host_out_data)
  );

  assign bus.host_in_ready  = !in_full;
  assign bus.host_out_valid = !out_empty;
  assign bus.cpu_int_sig    = int_q;
  assign bus.in_underflow   = flags_q.in_underflow;
  assign bus.out_overflow   = flags_q.out_overflow;

  // Interrupt event and sticky flags; a new error wins over clr_flags.
  always_comb begin
    int_d = bus.int_en && in_empty && in_push;
    flags_d.in_underflow = (bus.cpu_in_rd && in_empty) ||
                           (flags_q.in_underflow && !bus.clr_flags);
    flags_d.out_overflow = (bus.cpu_out_wr && out_full && !bus.host_out_ready) ||
                           (flags_q.out_overflow && !bus.clr_flags);
  end

  // Registered interrupt pulse and flags, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      int_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      int_q   <= int_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_io_port_periph.sv
// Scoreboard bench for io_port_periph: a queue-based reference model predicts
// per-cycle status and the bytes seen on IN reads and host output pops; a
// monitor on the falling edge pops and compares.
module tb_io_port_periph;
  import io_port_periph_pkg::*;

  localparam int DW    = CPU_DW;
  localparam int DEPTH = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  io_port_periph_if #(.DW(DW)) bus();

  io_port_periph #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic       ready;
    logic       valid;
    logic       intr;
    logic       uf;
    logic       of;
    logic [7:0] ip;
    logic [7:0] od;
  } stat_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_inq[$];
  logic [7:0] m_outq[$];
  bit m_uf, m_of, m_int, m_acc;

  // Scoreboard queues
  stat_t      stat_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] out_exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One clock cycle of stimulus plus the model's reaction to it.
  task automatic step(input bit iv, input logic [7:0] id, input bit rd, input bit wr,
                      input logic [7:0] wd, input bit ordy, input bit ien,
                      input bit clr, input bit rn);
    stat_t s;
    bit in_empty, in_full, out_full, ovf;
    bus.host_in_valid  = iv;
    bus.host_in_data   = id;
    bus.cpu_in_rd      = rd;
    bus.cpu_out_wr     = wr;
    bus.cpu_o_port     = wd;
    bus.host_out_ready = ordy;
    bus.int_en         = ien;
    bus.clr_flags      = clr;
    rstn               = rn;
    s.ready = (m_inq.size() < DEPTH);
    s.ip    = (m_inq.size() > 0) ? m_inq[0] : 8'h00;
    s.valid = (m_outq.size() > 0);
    s.od    = (m_outq.size() > 0) ? m_outq[0] : 8'h00;
    s.intr  = m_int;
    s.uf    = m_uf;
    s.of    = m_of;
    stat_q.push_back(s);
    if (rd) rd_exp_q.push_back(s.ip);
    if (ordy && m_outq.size() > 0) out_exp_q.push_back(m_outq[0]);
    @(posedge clk);
    #1;
    if (!rn) begin
      m_inq.delete();
      m_outq.delete();
      m_uf = 0; m_of = 0; m_int = 0; m_acc = 0;
    end else begin
      in_empty = (m_inq.size() == 0);
      in_full  = (m_inq.size() == DEPTH);
      out_full = (m_outq.size() == DEPTH);
      m_acc = iv && !in_full;
      if (rd && !in_empty) void'(m_inq.pop_front());
      if (m_acc) m_inq.push_back(id);
      m_int = m_acc && in_empty && ien;
      m_uf  = (rd && in_empty) || (m_uf && !clr);
      ovf   = wr && out_full && !ordy;
      if (ordy && m_outq.size() > 0) void'(m_outq.pop_front());
      if (wr && !ovf) m_outq.push_back(wd);
      m_of  = ovf || (m_of && !clr);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1);
  endtask

  // Monitor: compares status every active cycle and data on handshakes.
  stat_t ms;
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      ms = stat_q.pop_front();
      chk("host_in_ready",  bus.host_in_ready,  ms.ready);
      chk("cpu_i_port",     bus.cpu_i_port,     ms.ip);
      chk("host_out_valid", bus.host_out_valid, ms.valid);
      chk("host_out_data",  bus.host_out_data,  ms.od);
      chk("cpu_int_sig",    bus.cpu_int_sig,    ms.intr);
      chk("in_underflow",   bus.in_underflow,   ms.uf);
      chk("out_overflow",   bus.out_overflow,   ms.of);
      if (bus.cpu_in_rd) begin
        if (rd_exp_q.size() == 0) chk("in_read_expected", 1, 0);
        else chk("in_read_byte", bus.cpu_i_port, rd_exp_q.pop_front());
      end
      if (bus.host_out_valid && bus.host_out_ready) begin
        if (out_exp_q.size() == 0) chk("out_pop_expected", 1, 0);
        else chk("out_pop_byte", bus.host_out_data, out_exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hold;
    logic [7:0] hd;
    logic [7:0] outs [5];
    bus.host_in_valid = 0; bus.host_in_data = 0; bus.cpu_in_rd = 0;
    bus.cpu_out_wr = 0; bus.cpu_o_port = 0; bus.host_out_ready = 0;
    bus.int_en = 0; bus.clr_flags = 0; rstn = 0;
    m_uf = 0; m_of = 0; m_int = 0; m_acc = 0;
    @(posedge clk);
    #1;

    // Reset values
    step(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    idle(1);

    // Three pushes with interrupts enabled, then three IN reads and one more
    step(1, 8'h05, 0, 0, 8'h00, 0, 1, 0, 1);
    step(1, 8'h03, 0, 0, 8'h00, 0, 1, 0, 1);
    step(1, 8'h07, 0, 0, 8'h00, 0, 1, 0, 1);
    idle(2);
    for (int k = 0; k < 3; k++) step(0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 1);
    idle(1);

    // IN on empty FIFO sets underflow; clear it
    step(0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 1);
    idle(2);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 1);
    idle(1);

    // Fill input FIFO with int_en low, hold a fifth byte, free one slot
    for (int k = 0; k < 4; k++) step(1, 8'h11 + 8'(k), 0, 0, 8'h00, 0, 0, 0, 1);
    step(1, 8'h15, 0, 0, 8'h00, 0, 0, 0, 1);
    step(1, 8'h15, 0, 0, 8'h00, 0, 0, 0, 1);
    step(1, 8'h15, 1, 0, 8'h00, 0, 0, 0, 1);
    step(1, 8'h15, 0, 0, 8'h00, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1);
    idle(1);

    // Five OUTs with host stalled: last one dropped, then drain
    outs[0] = 8'h08; outs[1] = 8'h05; outs[2] = 8'h05; outs[3] = 8'h05; outs[4] = 8'h09;
    for (int k = 0; k < 5; k++) step(0, 8'h00, 0, 1, outs[k], 0, 1, 0, 1);
    idle(1);
    for (int k = 0; k < 5; k++) step(0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 1);
    idle(1);

    // Full output FIFO, OUT with host ready: no overflow, 0x0A last
    for (int k = 0; k < 4; k++) step(0, 8'h00, 0, 1, 8'h01 + 8'(k), 0, 1, 0, 1);
    step(0, 8'h00, 0, 1, 8'h0A, 1, 1, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 8'h00, 0, 0, 8'h00, 1, 1, 0, 1);

    // Reset with two bytes in each FIFO and traffic in flight
    step(1, 8'h21, 0, 1, 8'h31, 0, 0, 0, 1);
    step(1, 8'h22, 0, 1, 8'h32, 0, 0, 0, 1);
    step(1, 8'h23, 1, 1, 8'h33, 1, 1, 0, 0);
    idle(2);

    // Randomized traffic; the host holds a byte until it is accepted
    hold = 0;
    hd = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (!hold && $urandom_range(0, 99) < 60) begin
        hold = 1;
        hd = 8'($urandom);
      end
      step(hold, hold ? hd : 8'h00,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40, 8'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) >= 1);
      if (m_acc) hold = 0;
    end
    idle(1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", stat_q.size() + rd_exp_q.size() + out_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
